// File: rtl/nes_bus_pkg.sv
// Shared bus definitions for the NES system bus: register addresses and
// the OAM DMA engine state encoding.
package nes_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: owns the system bus, passes CPU cycles straight through
// while idle, and on a $4014 write stalls the CPU and copies one 256-byte
// page into the PPU OAM data port, one read/write pair per byte.
module oam_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF,
  parameter int          XFER_LEN      = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_d_out,
  input  logic        i_cpu_write,
  output logic        o_cpu_ready,
  input  logic [7:0]  i_bus_d_in,
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_d_out,
  output logic        o_bus_write,
  output logic        o_dma_busy
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t r_state;
  dma_state_t w_next_state;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_latch;
  logic       r_parity;
  logic       w_trigger;
  logic       w_last;

  // A trigger only counts while the CPU owns the bus.
  assign w_trigger = (r_state == IDLE) && i_cpu_write && (i_cpu_addr == DMA_REG_ADDR);
  assign w_last    = (r_idx == LAST_IDX);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; HALT skips ALIGN when parity already puts READ on a get cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = w_trigger ? HALT : IDLE;
      HALT:    w_next_state = r_parity ? READ : ALIGN;
      ALIGN:   w_next_state = READ;
      READ:    w_next_state = WRITE;
      WRITE:   w_next_state = w_last ? IDLE : READ;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: free-running parity, page/index capture, read-data latch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_parity <= 1'b0;
      r_page   <= 8'h00;
      r_idx    <= 8'h00;
      r_latch  <= 8'h00;
    end else begin
      r_parity <= ~r_parity;
      if (w_trigger) begin
        r_page <= i_cpu_d_out;
        r_idx  <= 8'h00;
      end else if ((r_state == WRITE) && !w_last) begin
        // idx stays 8 bits so it never carries into the page.
        r_idx <= r_idx + 8'h01;
      end else begin
        r_idx <= r_idx;
      end
      if (r_state == READ) begin
        r_latch <= i_bus_d_in;
      end else begin
        r_latch <= r_latch;
      end
    end
  end

  // Output mux: CPU pass-through when idle, DMA drive otherwise.
  always_comb begin
    o_bus_addr  = i_cpu_addr;
    o_bus_d_out = i_cpu_d_out;
    o_bus_write = i_cpu_write;
    case (r_state)
      IDLE: begin
        o_bus_addr  = i_cpu_addr;
        o_bus_d_out = i_cpu_d_out;
        o_bus_write = i_cpu_write;
      end
      HALT, ALIGN: begin
        o_bus_addr  = i_cpu_addr;
        o_bus_d_out = i_cpu_d_out;
        o_bus_write = 1'b0;
      end
      READ: begin
        o_bus_addr  = {r_page, r_idx};
        o_bus_d_out = i_cpu_d_out;
        o_bus_write = 1'b0;
      end
      WRITE: begin
        o_bus_addr  = OAM_DATA_ADDR;
        o_bus_d_out = r_latch;
        o_bus_write = 1'b1;
      end
      default: begin
        o_bus_addr  = i_cpu_addr;
        o_bus_d_out = i_cpu_d_out;
        o_bus_write = 1'b0;
      end
    endcase
  end

  assign o_cpu_ready = (r_state == IDLE);
  assign o_dma_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: a behavioural memory answers bus
// reads, a scoreboard queue holds the bytes expected at $2004, and a cycle
// model of the transfer sequence checks every stalled cycle.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic        cpu_ready;
  logic [7:0]  bus_d_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_write;
  logic        dma_busy;

  logic [7:0]  mem [0:65535];
  logic [7:0]  sb_q [$];
  logic        m_par;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  assign bus_d_in = mem[bus_addr];

  oam_dma_arbiter dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_d_out (cpu_d_out),
    .i_cpu_write (cpu_write),
    .o_cpu_ready (cpu_ready),
    .i_bus_d_in  (bus_d_in),
    .o_bus_addr  (bus_addr),
    .o_bus_d_out (bus_d_out),
    .o_bus_write (bus_write),
    .o_dma_busy  (dma_busy)
  );

  // Reference cycle parity: cleared by reset, toggles every clock.
  always @(posedge clk) begin
    if (reset) m_par <= 1'b0;
    else       m_par <= ~m_par;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every DMA write to OAM must match the next queued byte.
  always @(negedge clk) begin
    #2;
    if (dma_busy === 1'b1 && bus_write === 1'b1 && bus_addr === 16'h2004) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra_write", {24'h0, bus_d_out}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_oam_data", {24'h0, bus_d_out}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  // Trigger a transfer of 'page' with the given parity at HALT, then check
  // every stalled cycle. abort_at >= 0 asserts reset during that stall cycle.
  task automatic run_xfer(input logic [7:0] page, input logic halt_par,
                          input int exp_stall, input int abort_at);
    int stall;
    int base;
    int j;
    logic [15:0] ea;
    logic        ew;
    cpu_write = 1'b0;
    while ((~m_par) != halt_par) @(negedge clk);
    cpu_addr  = 16'h4014;
    cpu_d_out = page;
    cpu_write = 1'b1;
    for (int i = 0; i < 256; i++) sb_q.push_back(mem[{page, 8'(i)}]);
    #1;
    chk("trigger_pass", {7'h0, dma_busy, bus_write, bus_d_out, bus_addr},
        {7'h0, 1'b0, 1'b1, page, 16'h4014});
    @(negedge clk);
    cpu_addr  = 16'h8123;
    cpu_d_out = 8'h00;
    cpu_write = 1'b0;
    #1;
    base  = halt_par ? 1 : 2;
    stall = 0;
    while (cpu_ready === 1'b0 && stall < 600) begin
      if (stall < base) begin
        ea = 16'h8123; ew = 1'b0;
      end else begin
        j  = (stall - base) / 2;
        ea = ((stall - base) % 2 == 0) ? {page, 8'(j)} : 16'h2004;
        ew = ((stall - base) % 2 == 1);
      end
      chk("stall_seq", {14'h0, dma_busy, ew ? 1'b1 : bus_write, bus_addr},
          {14'h0, 1'b1, ew, ea});
      if (stall == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_state", {13'h0, cpu_ready, dma_busy, 1'b0, bus_addr},
            {13'h0, 1'b1, 1'b0, 1'b0, cpu_addr});
        reset = 1'b0;
        sb_q.delete();
        return;
      end
      stall++;
      @(negedge clk);
      #1;
    end
    chk("stall_len", stall, exp_stall);
    chk("end_state", {30'h0, cpu_ready, dma_busy}, {30'h0, 1'b1, 1'b0});
    chk("sb_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ew;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{16'h4015, 8'h11, 1'b1, 16'h4015, 8'h11, 1'b1};
    vecs[1] = '{16'h4013, 8'h22, 1'b1, 16'h4013, 8'h22, 1'b1};
    vecs[2] = '{16'h4014, 8'h33, 1'b0, 16'h4014, 8'h33, 1'b0};
    vecs[3] = '{16'h2004, 8'h44, 1'b1, 16'h2004, 8'h44, 1'b1};
    vecs[4] = '{16'h0000, 8'h55, 1'b0, 16'h0000, 8'h55, 1'b0};
    vecs[5] = '{16'hFFFF, 8'h66, 1'b1, 16'hFFFF, 8'h66, 1'b1};
    vecs[6] = '{16'h4014, 8'h77, 1'b0, 16'h4014, 8'h77, 1'b0};

    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
    for (int i = 0; i < 256; i++) mem[16'h0300 + 16'(i)] = 8'(i) ^ 8'hA5;

    reset = 1'b1; cpu_addr = 16'h1234; cpu_d_out = 8'h5A; cpu_write = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", {13'h0, cpu_ready, dma_busy, bus_write, bus_addr},
        {13'h0, 1'b1, 1'b0, 1'b0, 16'h1234});
    reset = 1'b0;
    @(negedge clk);

    // Non-triggering CPU accesses: pure pass-through, no stall.
    for (int v = 0; v < 7; v++) begin
      cpu_addr = vecs[v].a; cpu_d_out = vecs[v].d; cpu_write = vecs[v].w;
      #1;
      chk("vec_pass", {7'h0, bus_write, bus_d_out, bus_addr},
          {7'h0, vecs[v].ew, vecs[v].ed, vecs[v].ea});
      @(negedge clk);
      #1;
      chk("vec_idle", {30'h0, cpu_ready, dma_busy}, {30'h0, 1'b1, 1'b0});
    end
    cpu_write = 1'b0;
    @(negedge clk);

    // Parity 1 at HALT: no ALIGN, 513-cycle stall.
    run_xfer(8'h02, 1'b1, 513, -1);
    // Parity 0 at HALT: one ALIGN, 514-cycle stall.
    run_xfer(8'h02, 1'b0, 514, -1);
    // Preset pattern page, data must stream A5, A4, ... in order.
    run_xfer(8'h03, 1'b1, 513, -1);
    // Reset during the WRITE of idx 100, then restart on page $05.
    run_xfer(8'h03, 1'b1, 513, 202);
    run_xfer(8'h05, 1'b0, 514, -1);
    // Top page: addresses $FF00..$FFFF, no carry.
    run_xfer(8'hFF, 1'b1, 513, -1);

    // Reset coincident with a trigger: reset wins.
    @(negedge clk);
    reset = 1'b1; cpu_addr = 16'h4014; cpu_d_out = 8'h07; cpu_write = 1'b1;
    @(negedge clk);
    reset = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0010;
    #1;
    chk("reset_vs_trigger", {30'h0, cpu_ready, dma_busy}, {30'h0, 1'b1, 1'b0});
    @(negedge clk);
    #1;
    chk("reset_vs_trigger2", {30'h0, cpu_ready, dma_busy}, {30'h0, 1'b1, 1'b0});

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
